// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 host states, command bytes and frame builder
package ps2_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_START,
    ST_BITS,
    ST_ACK,
    ST_WAIT_IDLE
  } state_t;
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESEND   = 8'hFE;
  localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;
  // {stop, odd parity, data, start}: bit 0 is the start bit driven during REQ/START
  function automatic logic [10:0] ps2_frame(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction
endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-FF synchroniser, FILTER_LEN-sample debounce and falling-edge strobe
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_fall
);
  localparam int CW = $clog2(FILTER_LEN) + 1;
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_fall;
  // level changes only after FILTER_LEN consecutive differing synchronised samples
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync  <= 2'b11;
      r_cnt   <= '0;
      r_level <= 1'b1;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_pin};
      r_fall <= 1'b0;
      if (r_sync[1] == r_level) r_cnt <= '0;
      else if (r_cnt == CW'(FILTER_LEN - 1)) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
        r_fall  <= r_level;
      end else r_cnt <= r_cnt + 1'b1;
    end
  end
  assign o_level = r_level;
  assign o_fall  = r_fall;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter with ACK check and timeout
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  input  logic       i_ps2_clk_in,
  input  logic       i_ps2_data_in,
  output logic       o_ps2_clk_oe,
  output logic       o_ps2_data_oe,
  output logic       o_busy,
  output logic       o_rx_inhibit,
  output logic       o_done,
  output logic       o_ack_ok,
  output logic       o_err
);
  localparam logic [20:0] INH_LAST = 21'(INHIBIT_CYCLES - 1);
  localparam logic [20:0] TO_LAST  = 21'(TIMEOUT_CYCLES - 1);
  state_t      r_state;
  logic [20:0] r_cnt;
  logic [3:0]  r_idx;
  logic [10:0] r_frame;
  logic        r_clk_oe, r_data_oe, r_done, r_err, r_ack_ok, r_nack;
  logic        w_clk_lvl, w_clk_fall, w_data_lvl, w_unused_data_fall;
  logic [3:0]  w_idx;
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pin(i_ps2_clk_in), .o_level(w_clk_lvl), .o_fall(w_clk_fall)
  );
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pin(i_ps2_data_in), .o_level(w_data_lvl), .o_fall(w_unused_data_fall)
  );
  assign w_idx = (r_state == ST_START) ? 4'd1 : r_idx;
  // request sequencer: inhibit, start bit, clock out data/parity/stop, check ACK, wait for idle bus
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_frame   <= '0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_ack_ok  <= 1'b0;
      r_nack    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: if (i_tx_valid) begin
          r_frame   <= ps2_frame(i_tx_data);
          r_cnt     <= '0;
          r_ack_ok  <= 1'b0;
          r_nack    <= 1'b0;
          r_clk_oe  <= 1'b1;
          r_data_oe <= 1'b0;
          r_state   <= ST_INHIBIT;
        end
        ST_INHIBIT: if (r_cnt == INH_LAST) begin
          r_data_oe <= 1'b1;
          r_state   <= ST_REQ;
        end else r_cnt <= r_cnt + 1'b1;
        ST_REQ: begin
          r_clk_oe <= 1'b0;
          r_cnt    <= '0;
          r_state  <= ST_START;
        end
        default: if (r_state == ST_WAIT_IDLE && w_clk_lvl && w_data_lvl) begin
          r_done  <= 1'b1;
          r_err   <= r_nack;
          r_state <= ST_IDLE;
        end else if (w_clk_fall) begin
          r_cnt <= '0;
          if (r_state == ST_ACK) begin
            r_ack_ok <= ~w_data_lvl;
            r_nack   <= w_data_lvl;
            r_state  <= ST_WAIT_IDLE;
          end else if (r_state != ST_WAIT_IDLE) begin
            r_data_oe <= ~r_frame[w_idx];
            r_idx     <= w_idx + 1'b1;
            r_state   <= (w_idx == 4'd10) ? ST_ACK : ST_BITS;
          end
        end else if (r_cnt == TO_LAST) begin
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          r_ack_ok  <= 1'b0;
          r_done    <= 1'b1;
          r_err     <= 1'b1;
          r_state   <= ST_IDLE;
        end else r_cnt <= r_cnt + 1'b1;
      endcase
    end
  end
  assign o_tx_ready    = (r_state == ST_IDLE);
  assign o_busy        = (r_state != ST_IDLE);
  assign o_rx_inhibit  = o_busy;
  assign o_ps2_clk_oe  = r_clk_oe;
  assign o_ps2_data_oe = r_data_oe;
  assign o_done        = r_done;
  assign o_ack_ok      = r_ack_ok;
  assign o_err         = r_err;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: open-drain bus plus behavioural keyboard model checking host command frames
module tb_ps2_host_tx;
  localparam int INH = 100;
  localparam int TO  = 20000;
  localparam int FL  = 4;
  localparam int H   = 40;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       dev_c = 1'b0;
  logic       dev_d = 1'b0;
  logic       tx_ready, clk_oe, data_oe, busy, rx_inh, done, ack_ok, err;
  logic       ps2_c, ps2_d;
  int         checks = 0;
  int         errors = 0;
  assign ps2_c = ~(clk_oe | dev_c);
  assign ps2_d = ~(data_oe | dev_d);
  always #5 clk = ~clk;
  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready),
    .i_ps2_clk_in(ps2_c), .i_ps2_data_in(ps2_d), .o_ps2_clk_oe(clk_oe), .o_ps2_data_oe(data_oe),
    .o_busy(busy), .o_rx_inhibit(rx_inh), .o_done(done), .o_ack_ok(ack_ok), .o_err(err)
  );

  // expected bits as seen on the wire, first received in bit 0: data LSB-first, odd parity, stop
  function automatic logic [9:0] model_bits(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, ones % 2 == 0, d};
  endfunction

  // keyboard: watch the inhibit, then clock nfalls bits in (falls > 10 adds the ACK clock)
  task automatic dev_frame(input int nfalls, input bit nack, input bit glitch,
                           output logic [9:0] bits, output int inh, output logic sb, output bit ok);
    int t = 0;
    bits = '0; inh = 0; sb = 1'b1; ok = 1'b1;
    while (ps2_c && t < 50) begin @(negedge clk); t++; end
    if (ps2_c) begin ok = 1'b0; return; end
    while (!ps2_c && inh < 1000) begin @(negedge clk); inh++; end
    sb = ps2_d;
    if (nfalls == 0) return;
    repeat (H) @(negedge clk);
    for (int k = 0; k < nfalls && k < 10; k++) begin
      dev_c = 1'b1;
      repeat (H) @(negedge clk);
      bits[k] = ps2_d;
      dev_c = 1'b0;
      if (glitch && k == 3) begin
        repeat (H / 2) @(negedge clk);
        dev_c = 1'b1;
        repeat (2) @(negedge clk);
        dev_c = 1'b0;
        repeat (H / 2 - 2) @(negedge clk);
      end else repeat (H) @(negedge clk);
    end
    if (nfalls > 10) begin
      dev_d = !nack;
      repeat (H / 2) @(negedge clk);
      dev_c = 1'b1;
      repeat (H) @(negedge clk);
      dev_c = 1'b0;
      dev_d = 1'b0;
    end
  endtask

  task automatic run_tx(input logic [7:0] d, input bit nack, input bit glitch, input bit hold,
                        output logic [9:0] bits);
    int inh, n;
    logic sb;
    bit ok;
    @(negedge clk);
    tx_data = d;
    tx_valid = 1'b1;
    @(negedge clk);
    if (!hold) tx_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || rx_inh !== 1'b1 || tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL accept: busy=%b rx_inhibit=%b tx_ready=%b, need 1 1 0", busy, rx_inh, tx_ready);
    end
    if (hold) begin
      fork
        dev_frame(11, nack, glitch, bits, inh, sb, ok);
        repeat (400) begin @(negedge clk); tx_data = 8'($urandom); end
      join
    end else dev_frame(11, nack, glitch, bits, inh, sb, ok);
    checks++;
    if (!ok || inh !== INH + 1 || sb !== 1'b0) begin
      errors++;
      $display("FAIL inhibit: seen=%b clk_low=%0d start=%b, need 1 %0d 0", ok, inh, sb, INH + 1);
    end
    checks++;
    if (bits !== model_bits(d)) begin
      errors++;
      $display("FAIL frame %h: got %b need %b", d, bits, model_bits(d));
    end
    n = 0;
    while (done !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
    tx_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || ack_ok !== !nack || err !== nack) begin
      errors++;
      $display("FAIL done %h: done=%b ack_ok=%b err=%b, need 1 %b %b", d, done, ack_ok, err, !nack, nack);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || err !== 1'b0 || clk_oe !== 1'b0 || data_oe !== 1'b0 || tx_ready !== 1'b1 || ack_ok !== !nack) begin
      errors++;
      $display("FAIL after %h: done=%b err=%b oe=%b%b ready=%b ack_ok=%b", d, done, err, clk_oe, data_oe, tx_ready, ack_ok);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1 || clk_oe !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle %h: ready=%b clk_oe=%b busy=%b, need 1 0 0", d, tx_ready, clk_oe, busy);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({tx_ready, busy, rx_inh, clk_oe, data_oe, done, ack_ok, err} !== 8'b1000_0000) begin
      errors++;
      $display("FAIL reset: outputs=%b need 10000000", {tx_ready, busy, rx_inh, clk_oe, data_oe, done, ack_ok, err});
    end
  endtask

  task automatic test_set_leds;
    logic [9:0] bits;
    run_tx(8'hED, 1'b0, 1'b0, 1'b0, bits);
    checks++;
    if (bits !== 10'b11_1110_1101) begin
      errors++;
      $display("FAIL set_leds wire: got %b need 1111101101", bits);
    end
  endtask

  task automatic test_parity;
    logic [9:0] bits;
    run_tx(8'h00, 1'b0, 1'b0, 1'b0, bits);
    checks++;
    if (bits[8] !== 1'b1) begin errors++; $display("FAIL parity 00: got %b need 1", bits[8]); end
    run_tx(8'h01, 1'b0, 1'b0, 1'b0, bits);
    checks++;
    if (bits[8] !== 1'b0) begin errors++; $display("FAIL parity 01: got %b need 0", bits[8]); end
  endtask

  task automatic test_nack;
    logic [9:0] bits;
    run_tx(8'hFF, 1'b1, 1'b0, 1'b0, bits);
  endtask

  task automatic test_timeout;
    logic [9:0] bits;
    int inh, n;
    logic sb;
    bit ok;
    @(negedge clk);
    tx_data = 8'hF4;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    dev_frame(0, 1'b0, 1'b0, bits, inh, sb, ok);
    n = 0;
    while (done !== 1'b1 && n < TO + 200) begin @(negedge clk); n++; end
    checks++;
    if (n !== TO || done !== 1'b1 || err !== 1'b1 || ack_ok !== 1'b0) begin
      errors++;
      $display("FAIL timeout: cycles=%0d done=%b err=%b ack_ok=%b, need %0d 1 1 0", n, done, err, ack_ok, TO);
    end
    checks++;
    if (clk_oe !== 1'b0 || data_oe !== 1'b0 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout lines: oe=%b%b ready=%b, need 00 1", clk_oe, data_oe, tx_ready);
    end
  endtask

  task automatic test_reset_mid;
    logic [9:0] bits;
    int inh, pulses;
    logic sb;
    bit ok;
    @(negedge clk);
    tx_data = 8'($urandom);
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    dev_frame(5, 1'b0, 1'b0, bits, inh, sb, ok);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (clk_oe !== 1'b0 || data_oe !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: oe=%b%b busy=%b done=%b ready=%b, need 00 0 0 1", clk_oe, data_oe, busy, done, tx_ready);
    end
    rst_n = 1'b1;
    pulses = 0;
    repeat (60) begin @(negedge clk); pulses += int'(done); end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL reset_mid done pulses: got %0d need 0", pulses); end
    run_tx(8'($urandom), 1'b0, 1'b0, 1'b0, bits);
  endtask

  task automatic test_hold_glitch;
    logic [9:0] bits;
    run_tx(8'hA5, 1'b0, 1'b1, 1'b1, bits);
  endtask

  task automatic test_random;
    logic [9:0] bits;
    repeat (4) run_tx(8'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0, bits);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_set_leds;
    test_parity;
    test_nack;
    test_timeout;
    test_reset_mid;
    test_hold_glitch;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
